// File: rtl/pad_input_filter_if.sv
// Pad-ring side bus of pad_input_filter: raw pad levels and controls in, filtered levels and events out.
// The IRQ signals exist only when PAD_INPUT_FILTER_IRQ_EN is defined.
interface pad_input_filter_if #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] pad_c_i;
  logic [CNT_W-1:0] filt_len_i;
  logic [WIDTH-1:0] bypass_i;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             changed_o;
`ifdef PAD_INPUT_FILTER_IRQ_EN
  logic [WIDTH-1:0] irq_mask_i;
  logic [WIDTH-1:0] irq_clr_i;
  logic [WIDTH-1:0] irq_pend_o;
  logic             irq_o;

  modport master (
    output pad_c_i, filt_len_i, bypass_i, irq_mask_i, irq_clr_i,
    input  data_o, rise_o, fall_o, changed_o, irq_pend_o, irq_o
  );
  modport slave (
    input  pad_c_i, filt_len_i, bypass_i, irq_mask_i, irq_clr_i,
    output data_o, rise_o, fall_o, changed_o, irq_pend_o, irq_o
  );
`else
  modport master (
    output pad_c_i, filt_len_i, bypass_i,
    input  data_o, rise_o, fall_o, changed_o
  );
  modport slave (
    input  pad_c_i, filt_len_i, bypass_i,
    output data_o, rise_o, fall_o, changed_o
  );
`endif
endinterface

// File: rtl/pad_input_filter.sv
// Per-bit synchroniser + programmable debounce filter for pad receive outputs, with rise/fall event pulses.
// Optional sticky interrupt pending logic is built when PAD_INPUT_FILTER_IRQ_EN is defined.
module pad_input_filter #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned SYNC_STAGES = 2,   // legal range 2..4
  parameter int unsigned CNT_W       = 8
) (
  input logic           clk,
  input logic           rst,
  pad_input_filter_if.slave bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;
  logic [WIDTH-1:0][CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0]       w_cnt_nxt;
  logic [WIDTH-1:0]                  r_data;
  logic [WIDTH-1:0]                  w_data_nxt;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic [WIDTH-1:0]                  w_rise_nxt;
  logic [WIDTH-1:0]                  w_fall_nxt;
  logic                              r_changed;

  // Stage 0 samples the asynchronous pads; the last stage feeds the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_c_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Counter runs only while the synchronised level disagrees with data_o; >= lets a shortened length commit at once.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_data_nxt = r_data;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.bypass_i[i]) begin
        w_data_nxt[i] = w_s[i];
        w_cnt_nxt[i]  = '0;
      end else if (w_s[i] != r_data[i]) begin
        if (r_cnt[i] >= bus.filt_len_i) begin
          w_data_nxt[i] = w_s[i];
          w_cnt_nxt[i]  = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else begin
        w_cnt_nxt[i] = '0;
      end
    end
  end

  assign w_rise_nxt = w_data_nxt & ~r_data;
  assign w_fall_nxt = r_data & ~w_data_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign bus.data_o    = r_data;
  assign bus.rise_o    = r_rise;
  assign bus.fall_o    = r_fall;
  assign bus.changed_o = r_changed;

`ifdef PAD_INPUT_FILTER_IRQ_EN
  logic [WIDTH-1:0] r_irq_pend;
  logic             r_irq;

  // Pending bits latch visible events one cycle later; a same-cycle set beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_pend <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_pend <= (r_irq_pend & ~bus.irq_clr_i) | ((r_rise | r_fall) & bus.irq_mask_i);
      r_irq      <= |r_irq_pend;
    end
  end

  assign bus.irq_pend_o = r_irq_pend;
  assign bus.irq_o      = r_irq;
`endif

endmodule

// File: tb/tb_pad_input_filter.sv
// Self-checking bench for pad_input_filter: directed scenarios plus random traffic against a timestamp-based model.
// IRQ scenario is compiled only with PAD_INPUT_FILTER_IRQ_EN.
module tb_pad_input_filter;
  localparam int unsigned WIDTH = 11;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pad_input_filter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pad_input_filter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pad values wait SYNC cycles in a queue; a bit commits once it has disagreed
  // with the output since a recorded cycle for at least filt_len further cycles.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_data = '0, m_rise = '0, m_fall = '0;
  logic             m_changed = 1'b0;
  int               m_since [WIDTH];
  int               cyc = 0;
`ifdef PAD_INPUT_FILTER_IRQ_EN
  logic [WIDTH-1:0] m_pend = '0;
  logic             m_irq = 1'b0;
`endif

  always @(posedge clk) begin
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] nd;
    cyc++;
    if (rst) begin
      m_q.delete();
      for (int k = 0; k < int'(SYNC); k++) m_q.push_back('0);
      for (int i = 0; i < int'(WIDTH); i++) m_since[i] = -1;
      m_data = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
`ifdef PAD_INPUT_FILTER_IRQ_EN
      m_pend = '0; m_irq = 1'b0;
`endif
    end else begin
`ifdef PAD_INPUT_FILTER_IRQ_EN
      m_irq  = |m_pend;
      m_pend = (m_pend & ~bus.irq_clr_i) | ((m_rise | m_fall) & bus.irq_mask_i);
`endif
      s = m_q.pop_front();
      m_q.push_back(bus.pad_c_i);
      nd = m_data;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bus.bypass_i[i] || s[i] === m_data[i]) begin
          if (bus.bypass_i[i]) nd[i] = s[i];
          m_since[i] = -1;
        end else begin
          if (m_since[i] < 0) m_since[i] = cyc;
          if (cyc - m_since[i] >= int'(bus.filt_len_i)) begin
            nd[i] = s[i];
            m_since[i] = -1;
          end
        end
      end
      m_rise = nd & ~m_data;
      m_fall = m_data & ~nd;
      m_changed = |(m_rise | m_fall);
      m_data = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int hit;
    rst = 1'b1;
    bus.pad_c_i = ALL1; bus.filt_len_i = 8'd4; bus.bypass_i = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.data_o !== '0 || bus.rise_o !== '0 || bus.fall_o !== '0 || bus.changed_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: data=%h rise=%h fall=%h chg=%b, want all 0", bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o);
      end
    end
    rst = 1'b0;
    hit = 0;
    for (int c = 1; c <= 20 && hit == 0; c++) begin
      tick();
      checks++;
      if ({bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o} !== {m_data, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL reset_model: data=%h rise=%h fall=%h chg=%b, want %h %h %h %b", bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o, m_data, m_rise, m_fall, m_changed);
      end
      if (bus.data_o === ALL1) hit = c;
    end
    checks++;
    if (hit < 6 || hit > 8) begin
      errors++;
      $display("FAIL reset_latency: got %0d cycles, want 7 (+/-1)", hit);
    end
    checks++;
    if (bus.rise_o !== ALL1 || bus.changed_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_rise: rise=%h chg=%b, want %h 1", bus.rise_o, bus.changed_o, ALL1);
    end
    tick();
    checks++;
    if (bus.rise_o !== '0 || bus.changed_o !== 1'b0 || bus.data_o !== ALL1) begin
      errors++;
      $display("FAIL reset_pulse_len: rise=%h chg=%b data=%h, want 0 0 %h", bus.rise_o, bus.changed_o, bus.data_o, ALL1);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int rises3 = 0;
    bus.filt_len_i = 8'd5; bus.pad_c_i = '0;
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if (bus.data_o !== '0) begin
      errors++;
      $display("FAIL glitch_settle: data=%h, want 0", bus.data_o);
    end
    for (int c = 0; c < 14; c++) begin
      bus.pad_c_i[3] = (c < 4);
      tick();
      checks++;
      if ({bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o} !== {m_data, m_rise, m_fall, m_changed}) begin
        errors++;
        $display("FAIL glitch_model: data=%h rise=%h fall=%h, want %h %h %h", bus.data_o, bus.rise_o, bus.fall_o, m_data, m_rise, m_fall);
      end
      if ((bus.rise_o | bus.fall_o) !== '0) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.data_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: pulses=%0d data3=%b, want 0 0", pulses, bus.data_o[3]);
    end
    bus.pad_c_i[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.rise_o[3] === 1'b1) rises3++;
    end
    checks++;
    if (rises3 != 1 || bus.data_o[3] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_accept: rises=%0d data3=%b, want 1 1", rises3, bus.data_o[3]);
    end
  endtask

  task automatic test_len_drop();
    int extra = 0;
    bus.filt_len_i = 8'd200; bus.pad_c_i[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({bus.data_o, bus.rise_o, bus.fall_o} !== {m_data, m_rise, m_fall}) begin
        errors++;
        $display("FAIL lendrop_model: data=%h rise=%h fall=%h, want %h %h %h", bus.data_o, bus.rise_o, bus.fall_o, m_data, m_rise, m_fall);
      end
    end
    checks++;
    if (bus.data_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL lendrop_pending: data0=%b, want 0", bus.data_o[0]);
    end
    bus.filt_len_i = 8'd3;
    tick();
    checks++;
    if (bus.rise_o !== 11'h001 || bus.data_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL lendrop_commit: rise=%h data0=%b, want 001 1", bus.rise_o, bus.data_o[0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.rise_o[0] === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL lendrop_single: extra rises=%0d, want 0", extra);
    end
  endtask

  task automatic test_bypass();
    logic hist [48];
    int nr = 0, nf = 0, np = 0;
    bus.filt_len_i = 8'd255; bus.bypass_i[7] = 1'b1; bus.pad_c_i[7] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c % 4 == 0) bus.pad_c_i[7] = ~bus.pad_c_i[7];
      hist[c] = bus.pad_c_i[7];
      tick();
      if (bus.rise_o[7] === 1'b1) nr++;
      if (bus.fall_o[7] === 1'b1) nf++;
      if (c >= 2) begin
        checks++;
        if (bus.data_o[7] !== hist[c-2] || bus.data_o !== m_data) begin
          errors++;
          $display("FAIL bypass_track c=%0d: data=%h, want bit7=%b model=%h", c, bus.data_o, hist[c-2], m_data);
        end
      end
    end
    checks++;
    if (nr != 3 || nf != 3) begin
      errors++;
      $display("FAIL bypass_pulses: rises=%0d falls=%0d, want 3 3", nr, nf);
    end
    bus.bypass_i[7] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c % 4 == 0) bus.pad_c_i[7] = ~bus.pad_c_i[7];
      tick();
      if ((bus.rise_o[7] | bus.fall_o[7]) === 1'b1) np++;
      checks++;
      if ({bus.data_o, bus.rise_o, bus.fall_o} !== {m_data, m_rise, m_fall}) begin
        errors++;
        $display("FAIL bypass_off_model: data=%h rise=%h fall=%h, want %h %h %h", bus.data_o, bus.rise_o, bus.fall_o, m_data, m_rise, m_fall);
      end
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL bypass_off_filter: pulses=%0d, want 0", np);
    end
  endtask

  task automatic test_simul_fall();
    int nf = 0, nc = 0, nr = 0;
    logic [WIDTH-1:0] fv = '0;
    bus.filt_len_i = 8'd2; bus.pad_c_i = 11'h202;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (bus.data_o !== 11'h202) begin
      errors++;
      $display("FAIL simul_setup: data=%h, want 202", bus.data_o);
    end
    bus.pad_c_i = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.fall_o !== '0) begin nf++; fv = bus.fall_o; end
      if (bus.rise_o !== '0) nr++;
      if (bus.changed_o === 1'b1) nc++;
    end
    checks++;
    if (nf != 1 || fv !== 11'h202) begin
      errors++;
      $display("FAIL simul_fall: cycles=%0d fall=%h, want 1 202", nf, fv);
    end
    checks++;
    if (nc != 1 || nr != 0) begin
      errors++;
      $display("FAIL simul_changed: changed=%0d rises=%0d, want 1 0", nc, nr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) bus.pad_c_i[$urandom_range(0, WIDTH-1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) bus.bypass_i = WIDTH'($urandom) & WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0) bus.filt_len_i = CNT_W'($urandom_range(0, 6));
      tick();
      checks++;
      if ({bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o} !== {m_data, m_rise, m_fall, m_changed}
          || (bus.rise_o & bus.fall_o) !== '0) begin
        errors++;
        $display("FAIL random c=%0d: data=%h rise=%h fall=%h chg=%b, want %h %h %h %b", c, bus.data_o, bus.rise_o, bus.fall_o, bus.changed_o, m_data, m_rise, m_fall, m_changed);
      end
    end
    rst = 1'b0;
  endtask

`ifdef PAD_INPUT_FILTER_IRQ_EN
  task automatic test_irq();
    int w;
    bus.bypass_i = '0; bus.filt_len_i = 8'd1; bus.pad_c_i = '0;
    bus.irq_mask_i = 11'h004; bus.irq_clr_i = 11'h7ff;
    for (int c = 0; c < 8; c++) tick();
    bus.irq_clr_i = '0;
    tick();
    bus.pad_c_i[2] = 1'b1;
    w = 0;
    while (bus.rise_o[2] !== 1'b1 && w < 12) begin tick(); w++; end
    tick();
    checks++;
    if (bus.irq_pend_o !== 11'h004 || bus.irq_pend_o !== m_pend) begin
      errors++;
      $display("FAIL irq_set: pend=%h, want 004", bus.irq_pend_o);
    end
    tick();
    checks++;
    if (bus.irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_out: irq=%b, want 1", bus.irq_o);
    end
    bus.pad_c_i[2] = 1'b0;
    w = 0;
    while (bus.fall_o[2] !== 1'b1 && w < 12) begin tick(); w++; end
    bus.irq_clr_i = 11'h004;
    tick();
    bus.irq_clr_i = '0;
    checks++;
    if (bus.irq_pend_o !== 11'h004) begin
      errors++;
      $display("FAIL irq_set_wins: pend=%h, want 004", bus.irq_pend_o);
    end
    tick(); tick();
    bus.irq_clr_i = 11'h004;
    tick();
    bus.irq_clr_i = '0;
    checks++;
    if (bus.irq_pend_o !== '0) begin
      errors++;
      $display("FAIL irq_clear: pend=%h, want 000", bus.irq_pend_o);
    end
    tick();
    checks++;
    if (bus.irq_o !== 1'b0 || {bus.irq_pend_o, bus.irq_o} !== {m_pend, m_irq}) begin
      errors++;
      $display("FAIL irq_drop: irq=%b pend=%h, want 0 000", bus.irq_o, bus.irq_pend_o);
    end
  endtask
`endif

  initial begin
    bus.pad_c_i = '0; bus.filt_len_i = '0; bus.bypass_i = '0;
`ifdef PAD_INPUT_FILTER_IRQ_EN
    bus.irq_mask_i = '0; bus.irq_clr_i = '0;
`endif
    test_reset();
    test_glitch();
    test_len_drop();
    test_bypass();
    test_simul_fall();
    test_random();
`ifdef PAD_INPUT_FILTER_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
